uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, 1023, max idle cycles mid-packet before lock release (1..65535).
REQ-003 Clk  input  1  single clock; all logic on rising edge.
REQ-004 Rst  input  1  reset; asynchronous, active-high.
REQ-005 i_Req  input  N_REQ  per-requester byte-valid, level, held until o_Ack.
REQ-006 i_Last  input  N_REQ  per-requester "this byte ends packet", qualified by i_Req.
REQ-007 i_Data  input  8*N_REQ  packed bytes, requester k at bits [8k+7:8k].
REQ-008 o_Ack  output  N_REQ  one-cycle pulse, byte of requester k accepted.
REQ-009 o_Grant  output  N_REQ  one-hot current owner, all-zero when idle.
REQ-010 o_fTx  output  1  one-cycle transmit strobe to UART transmitter.
REQ-011 o_Data  output  8  byte to transmit, stable from o_fTx until next o_fTx.
REQ-012 i_fReady  input  1  UART transmitter idle.
REQ-013 i_fDone  input  1  UART transmitter one-cycle end-of-byte pulse.
REQ-014 o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SEND, WAIT; all outputs registered, decoded from state and latched regs.
REQ-016 IDLE: any i_Req high -> pick winner round-robin, search from pointer+1 upward with wrap; register o_Grant; -> LOAD next cycle.
REQ-017 Simultaneous requests: lowest index at or after pointer+1 (mod N_REQ) wins; non-requesters never granted.
REQ-018 LOAD: i_Fready && i_Req[owner] -> latch i_Data[owner] and i_Last[owner], -> SEND.
REQ-019 SEND: exactly one cycle; o_fTx=1, o_Ack[owner]=1, o_Data=latched byte; -> WAIT.
REQ-020 WAIT: on i_fDone -> if latched Last: pointer=owner, o_Grant=0, -> IDLE; else -> LOAD, same owner (packet lock).
REQ-021 Minimum latency: i_Req rise in IDLE at cycle t with i_fReady high -> o_Grant at t+1, o_fTx/o_Ack at t+2.
REQ-022 Packet lock: other requesters' i_Req SHALL be ignored until owner's Last byte done or timeout.
REQ-023 Timeout counter SHALL count LOAD cycles with i_Req[owner] low; reaching TIMEOUT -> pointer=owner, -> IDLE, counter cleared; counter cleared on every entry to SEND.
REQ-024 i_Fready low in LOAD SHALL stall without counting toward timeout.
REQ-025 i_fDone outside WAIT SHALL be ignored.
REQ-026 Owner i_Data/i_Last changes after o_Ack SHALL not affect byte in flight.
REQ-027 o_Ack never asserted for more than one requester, never outside SEND.

Reset
REQ-028 Rst high SHALL immediately force IDLE, o_fTx=0, o_Ack=0, o_Grant=0, o_Busy=0, o_Data=8'h00, timeout counter=0, pointer=N_REQ-1 (requester 0 wins first).
REQ-029 Reset mid-packet SHALL discard latched byte and lock; no o_Ack or o_fTx after release until new arbitration.

Structure
REQ-030 Shared package uart_arb_pkg SHALL hold FSM state encoding, byte width constant 8, TIMEOUT width function.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req vector, pointer; output one-hot grant).
REQ-032 Target 150-300 lines RTL total.

Verification
REQ-033 Single byte: req0=1, data0=8'h3C, last0=1, fReady=1 -> o_Grant=0001 at t+1, o_fTx with o_Data=8'h3C at t+2, o_Ack[0] one cycle, IDLE after fDone.
REQ-034 Contention: req0..req3 all high, single-byte packets 8'h10..8'h13 -> transmit order 10,11,12,13, then repeat pattern 10 when re-requested.
REQ-035 Packet lock: req1 sends 8'hE5,8'hA1,8'h7F (last on 7F) while req2 high -> req2 byte sent only after 7F fDone.
REQ-036 Timeout: TIMEOUT=8, req0 drops after first non-last byte, req3 high -> after 8 LOAD cycles owner released, req3 granted next.
REQ-037 Stall: fReady low 50 cycles in LOAD with req high -> no o_fTx, no timeout; o_fTx one cycle after fReady rises.
REQ-038 Reset mid-WAIT: assert Rst one cycle during byte -> all outputs 0 immediately, next grant goes to requester 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and the sizing helper for the mid-packet idle counter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    // Number of bits needed to hold the value max_count (at least 1).
    function automatic int timeout_width(input int max_count);
        int w;
        w = 1;
        while ((1 << w) <= max_count) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector. The search starts at the requester
// just after the pointer and wraps, so the last owner has lowest priority.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Walk the requesters in priority order and grant the first one asserted.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_idx = PTR_W'((int'(i_ptr) + off) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources. Arbitration is
// round-robin per packet: once a requester wins, it keeps the transmitter
// until its Last byte completes or it stays silent for TIMEOUT load cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [N_REQ-1:0]        i_Req,
    input  logic [N_REQ-1:0]        i_Last,
    input  logic [BYTE_W*N_REQ-1:0] i_Data,
    output logic [N_REQ-1:0]        o_Ack,
    output logic [N_REQ-1:0]        o_Grant,
    output logic                    o_fTx,
    output logic [BYTE_W-1:0]       o_Data,
    input  logic                    i_fReady,
    input  logic                    i_fDone,
    output logic                    o_Busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TO_W  = timeout_width(TIMEOUT);

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic              r_last;
    logic [TO_W-1:0]   r_cnt;

    logic [N_REQ-1:0]  w_gnt;
    logic [PTR_W-1:0]  w_idx;
    logic              w_own_req;
    logic              w_own_last;
    logic [BYTE_W-1:0] w_own_data;
    logic              w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req   (i_Req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt)
    );

    // Encode the one-hot winner so the owner can be stored as an index.
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_idx = PTR_W'(k);
            end
        end
    end

    // Route the current owner's request, last flag and byte.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_owner == PTR_W'(k)) begin
                w_own_req  = i_Req[k];
                w_own_last = i_Last[k];
                w_own_data = i_Data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Last idle load cycle before the lock is dropped.
    always_comb begin
        w_timeout = (r_cnt == TO_W'(TIMEOUT - 1));
    end

    // Main FSM; every output is a register updated with the state transition.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= PTR_W'(N_REQ - 1);
            r_owner <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            o_Grant <= '0;
            o_Ack   <= '0;
            o_fTx   <= 1'b0;
            o_Data  <= '0;
            o_Busy  <= 1'b0;
        end else begin
            o_fTx <= 1'b0;
            o_Ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_Req) begin
                        o_Grant <= w_gnt;
                        r_owner <= w_idx;
                        o_Busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A transmitter that is not ready freezes everything,
                    // including the idle counter.
                    if (i_fReady) begin
                        if (w_own_req) begin
                            o_Data  <= w_own_data;
                            r_last  <= w_own_last;
                            o_fTx   <= 1'b1;
                            o_Ack   <= o_Grant;
                            r_cnt   <= '0;
                            r_state <= ST_SEND;
                        end else if (w_timeout) begin
                            r_ptr   <= r_owner;
                            o_Grant <= '0;
                            o_Busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + TO_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_fDone) begin
                        if (r_last) begin
                            r_ptr   <= r_owner;
                            o_Grant <= '0;
                            o_Busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed latency/lock/timeout/stall/reset steps
// plus randomized multi-packet traffic scored against a packet-level
// round-robin model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [N-1:0]   i_Req;
    logic [N-1:0]   i_Last;
    logic [8*N-1:0] i_Data;
    logic [N-1:0]   o_Ack;
    logic [N-1:0]   o_Grant;
    logic           o_fTx;
    logic [7:0]     o_Data;
    logic           i_fReady;
    logic           i_fDone;
    logic           o_Busy;

    int checks   = 0;
    int failures = 0;

    // Pending bytes per requester (head is presented on the bus).
    logic [7:0] rq_data [N][$];
    bit         rq_last [N][$];

    // Expected transmit stream from the model.
    logic [7:0] exp_q[$];
    int         exp_own_q[$];
    int         mdl_ptr;

    always #5 Clk = ~Clk;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_Req    (i_Req),
        .i_Last   (i_Last),
        .i_Data   (i_Data),
        .o_Ack    (o_Ack),
        .o_Grant  (o_Grant),
        .o_fTx    (o_fTx),
        .o_Data   (o_Data),
        .i_fReady (i_fReady),
        .i_fDone  (i_fDone),
        .o_Busy   (o_Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input bit last);
        rq_data[k].push_back(b);
        rq_last[k].push_back(last);
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            if (rq_data[k].size() > 0) begin
                i_Req[k]          = 1'b1;
                i_Data[k*8 +: 8]  = rq_data[k][0];
                i_Last[k]         = rq_last[k][0];
            end else begin
                i_Req[k]          = 1'b0;
                i_Data[k*8 +: 8]  = 8'h00;
                i_Last[k]         = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) begin
            rq_data[k].delete();
            rq_last[k].delete();
        end
        Rst      = 1'b1;
        i_Req    = '0;
        i_Last   = '0;
        i_Data   = '0;
        i_fDone  = 1'b0;
        i_fReady = 1'b1;
        tick();
        Rst      = 1'b0;
        mdl_ptr  = N - 1;
    endtask

    // Packet-level round robin: whole packets are sent back to back; after
    // each packet the search restarts just past the requester that sent it.
    task automatic build_expected();
        logic [7:0] d [N][$];
        bit         l [N][$];
        int         p;
        int         k;
        bit         found;
        bit         done;
        for (int j = 0; j < N; j++) begin
            d[j] = rq_data[j];
            l[j] = rq_last[j];
        end
        exp_q.delete();
        exp_own_q.delete();
        p = mdl_ptr;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int off = 1; off <= N; off++) begin
                k = (p + off) % N;
                if (!found && d[k].size() > 0) begin
                    found = 1'b1;
                    p     = k;
                    done  = 1'b0;
                    while (!done && d[k].size() > 0) begin
                        exp_q.push_back(d[k].pop_front());
                        exp_own_q.push_back(k);
                        done = l[k].pop_front();
                    end
                end
            end
        end
        mdl_ptr = p;
    endtask

    // Act as requesters and UART until all queued bytes are sent.
    task automatic serve(input bit rnd);
        int dcnt;
        int cyc;
        int own;
        int n_tx;
        bit empty;
        dcnt = 0;
        cyc  = 0;
        n_tx = 0;
        i_fDone  = 1'b0;
        i_fReady = 1'b1;
        drive_reqs();
        while (1) begin
            tick();
            cyc++;
            i_fDone = 1'b0;
            chk("ack_outside_send", 32'(|o_Ack && !o_fTx), 32'd0);
            if (o_fTx) begin
                if (n_tx < exp_q.size()) begin
                    chk("tx_data", 32'(o_Data), 32'(exp_q[n_tx]));
                    chk("tx_ack", 32'(o_Ack), 32'd1 << exp_own_q[n_tx]);
                    chk("tx_grant", 32'(o_Grant), 32'd1 << exp_own_q[n_tx]);
                end
                n_tx++;
                own = -1;
                for (int k = 0; k < N; k++) begin
                    if (o_Ack[k]) own = k;
                end
                if (own >= 0) begin
                    if (rq_data[own].size() > 0) begin
                        void'(rq_data[own].pop_front());
                        void'(rq_last[own].pop_front());
                    end
                end
                dcnt = rnd ? int'($urandom_range(1, 5)) : 1;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) i_fDone = 1'b1;
            end
            i_fReady = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_reqs();
            empty = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (rq_data[k].size() > 0) empty = 1'b0;
            end
            if (empty && !o_Busy && dcnt == 0 && !i_fDone) break;
            if (cyc > 5000) begin
                chk("serve_cycle_bound", 32'd0, 32'd1);
                break;
            end
        end
        i_fReady = 1'b1;
        chk("tx_count", 32'(n_tx), 32'(exp_q.size()));
    endtask

    initial begin
        int tx_seen;
        bit held;
        int npkt;
        int len;

        Rst      = 1'b1;
        i_Req    = '0;
        i_Last   = '0;
        i_Data   = '0;
        i_fReady = 1'b1;
        i_fDone  = 1'b0;
        tick();
        tick();
        chk("rst_grant", 32'(o_Grant), 32'd0);
        chk("rst_ftx",   32'(o_fTx),   32'd0);
        chk("rst_ack",   32'(o_Ack),   32'd0);
        chk("rst_busy",  32'(o_Busy),  32'd0);
        chk("rst_data",  32'(o_Data),  32'd0);
        Rst     = 1'b0;
        mdl_ptr = N - 1;

        // Single byte with minimum latency.
        i_Req       = 4'b0001;
        i_Last      = 4'b0001;
        i_Data[7:0] = 8'h3C;
        tick();
        chk("sb_grant",     32'(o_Grant), 32'h1);
        chk("sb_busy",      32'(o_Busy),  32'd1);
        chk("sb_ftx_early", 32'(o_fTx),   32'd0);
        tick();
        chk("sb_ftx",  32'(o_fTx),  32'd1);
        chk("sb_data", 32'(o_Data), 32'h3C);
        chk("sb_ack",  32'(o_Ack),  32'h1);
        i_Req  = '0;
        i_Last = '0;
        i_Data = '0;
        tick();
        chk("sb_ftx_pulse", 32'(o_fTx),  32'd0);
        chk("sb_ack_pulse", 32'(o_Ack),  32'd0);
        chk("sb_data_hold", 32'(o_Data), 32'h3C);
        chk("sb_busy_wait", 32'(o_Busy), 32'd1);
        i_fDone = 1'b1;
        tick();
        i_fDone = 1'b0;
        chk("sb_grant_idle", 32'(o_Grant), 32'd0);
        chk("sb_busy_idle",  32'(o_Busy),  32'd0);

        // Contention, twice, single-byte packets.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) push_byte(k, 8'(16 + k), 1'b1);
            build_expected();
            serve(1'b0);
        end

        // Packet lock against a competing requester.
        push_byte(1, 8'hE5, 1'b0);
        push_byte(1, 8'hA1, 1'b0);
        push_byte(1, 8'h7F, 1'b1);
        push_byte(2, 8'hC2, 1'b1);
        build_expected();
        serve(1'b0);

        // Stall in LOAD: no transmit, no timeout, strobe right after ready.
        push_byte(0, 8'h99, 1'b1);
        drive_reqs();
        i_fReady = 1'b0;
        tick();
        chk("st_grant", 32'(o_Grant), 32'h1);
        tx_seen = 0;
        repeat (50) begin
            tick();
            if (o_fTx) tx_seen++;
        end
        chk("st_no_tx", 32'(tx_seen), 32'd0);
        i_Req = '0;
        repeat (20) tick();
        chk("st_no_timeout", 32'(o_Grant), 32'h1);
        drive_reqs();
        tick();
        chk("st_still_stalled", 32'(o_fTx), 32'd0);
        i_fReady = 1'b1;
        tick();
        chk("st_ftx",  32'(o_fTx),  32'd1);
        chk("st_data", 32'(o_Data), 32'h99);
        void'(rq_data[0].pop_front());
        void'(rq_last[0].pop_front());
        drive_reqs();
        tick();
        i_fDone = 1'b1;
        tick();
        i_fDone = 1'b0;
        chk("st_idle", 32'(o_Grant), 32'd0);

        // Timeout: owner 0 goes silent mid-packet, requester 3 waiting.
        do_reset();
        push_byte(0, 8'hA0, 1'b0);
        push_byte(3, 8'h33, 1'b1);
        drive_reqs();
        tick();
        chk("to_grant0", 32'(o_Grant), 32'h1);
        tick();
        chk("to_ftx",  32'(o_fTx),  32'd1);
        chk("to_data", 32'(o_Data), 32'hA0);
        rq_data[0].delete();
        rq_last[0].delete();
        drive_reqs();
        tick();
        i_fDone = 1'b1;
        tick();
        i_fDone = 1'b0;
        chk("to_lock", 32'(o_Grant), 32'h1);
        held = 1'b1;
        repeat (TO - 1) begin
            tick();
            if (o_Grant !== 4'b0001) held = 1'b0;
        end
        chk("to_held", 32'(held), 32'd1);
        tick();
        chk("to_release_grant", 32'(o_Grant), 32'd0);
        chk("to_release_busy",  32'(o_Busy),  32'd0);
        tick();
        chk("to_next_grant", 32'(o_Grant), 32'h8);
        tick();
        chk("to_ftx3",  32'(o_fTx),  32'd1);
        chk("to_data3", 32'(o_Data), 32'h33);
        void'(rq_data[3].pop_front());
        void'(rq_last[3].pop_front());
        drive_reqs();
        tick();
        i_fDone = 1'b1;
        tick();
        i_fDone = 1'b0;
        chk("to_idle", 32'(o_Busy), 32'd0);
        mdl_ptr = 3;

        // Reset in the middle of a byte.
        push_byte(2, 8'h5A, 1'b1);
        drive_reqs();
        tick();
        chk("rw_grant", 32'(o_Grant), 32'h4);
        tick();
        chk("rw_ftx", 32'(o_fTx), 32'd1);
        void'(rq_data[2].pop_front());
        void'(rq_last[2].pop_front());
        drive_reqs();
        tick();
        Rst = 1'b1;
        #1;
        chk("rw_grant0", 32'(o_Grant), 32'd0);
        chk("rw_ftx0",   32'(o_fTx),   32'd0);
        chk("rw_ack0",   32'(o_Ack),   32'd0);
        chk("rw_busy0",  32'(o_Busy),  32'd0);
        chk("rw_data0",  32'(o_Data),  32'd0);
        tick();
        Rst     = 1'b0;
        mdl_ptr = N - 1;
        tx_seen = 0;
        repeat (3) begin
            tick();
            if (o_fTx || o_Ack != 0) tx_seen++;
        end
        chk("rw_no_tx_after", 32'(tx_seen), 32'd0);
        push_byte(0, 8'h0F, 1'b1);
        push_byte(2, 8'h2F, 1'b1);
        build_expected();
        serve(1'b0);

        // Randomized multi-packet traffic with random ready/done timing.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                npkt = int'($urandom_range(0, 3));
                for (int p = 0; p < npkt; p++) begin
                    len = int'($urandom_range(1, 4));
                    for (int j = 0; j < len; j++) begin
                        push_byte(k, 8'($urandom), j == len - 1);
                    end
                end
            end
            build_expected();
            serve(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
